// File: rtl/cdb_issue_scheduler_if.sv
// Issue/CDB signal bundle between the per-unit issue queues and the scheduler.
// The master drives ready/flush. The slave (scheduler) returns grants and CDB ownership.
interface cdb_issue_scheduler_if;
  logic       ready_int;
  logic       ready_mem;
  logic       ready_mult;
  logic       ready_div;
  logic       flush;
  logic       issue_int;
  logic       issue_mem;
  logic       issue_mult;
  logic       issue_div;
  logic       div_busy;
  logic       cdb_valid;
  logic [1:0] cdb_owner;

  modport master (
    output ready_int, ready_mem, ready_mult, ready_div, flush,
    input  issue_int, issue_mem, issue_mult, issue_div,
    input  div_busy, cdb_valid, cdb_owner
  );

  modport slave (
    input  ready_int, ready_mem, ready_mult, ready_div, flush,
    output issue_int, issue_mem, issue_mult, issue_div,
    output div_busy, cdb_valid, cdb_owner
  );
endinterface

// File: rtl/cdb_issue_scheduler.sv
// Issue-grant scheduler for the int/mem/mult/div pipes. It grants ready queue heads
// and pre-reserves each result's CDB cycle in a shifting slot register, so results never collide.
module cdb_issue_scheduler #(
  parameter int INT_LAT  = 1,
  parameter int MEM_LAT  = 1,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  cdb_issue_scheduler_if.slave  sched
);

  localparam int MAX_IM = (INT_LAT > MEM_LAT) ? INT_LAT : MEM_LAT;
  localparam int MAX_MD = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int MAXL   = (MAX_IM > MAX_MD) ? MAX_IM : MAX_MD;
  localparam int CW     = $clog2(DIV_LAT);

  typedef enum logic [1:0] {
    OWN_INT  = 2'd0,
    OWN_MEM  = 2'd1,
    OWN_MULT = 2'd2,
    OWN_DIV  = 2'd3
  } owner_e;

  typedef enum logic {
    PREF_INT = 1'b0,
    PREF_MEM = 1'b1
  } rr_e;

  logic [MAXL:0]      slot_q, slot_d;
  logic [MAXL:0][1:0] owner_q, owner_d;
  logic [CW-1:0]      div_cnt_q, div_cnt_d;
  rr_e                rr_q, rr_d;

  logic               can_issue;
  logic               div_busy;
  logic [MAXL:0]      claim;
  logic               int_ok, mem_ok;
  logic               g_int, g_mem, g_mult, g_div;

  // Grants are gated by reset too, so a ready held during reset never leaks out as an issue.
  assign can_issue = i_rst_n & ~sched.flush;
  assign div_busy  = |div_cnt_q;

  // Fixed priority div > mult > int/mem. The claim vector blocks a lower-priority unit
  // that would land on a slot already taken in this cycle.
  always_comb begin
    claim  = '0;
    g_div  = can_issue & sched.ready_div & ~div_busy & ~slot_q[DIV_LAT];
    if (g_div) claim[DIV_LAT] = 1'b1;

    g_mult = can_issue & sched.ready_mult & ~slot_q[MULT_LAT] & ~claim[MULT_LAT];
    if (g_mult) claim[MULT_LAT] = 1'b1;

    int_ok = can_issue & sched.ready_int & ~slot_q[INT_LAT] & ~claim[INT_LAT];
    mem_ok = can_issue & sched.ready_mem & ~slot_q[MEM_LAT] & ~claim[MEM_LAT];
    g_int  = int_ok;
    g_mem  = mem_ok;
    if ((INT_LAT == MEM_LAT) && int_ok && mem_ok) begin
      g_int = (rr_q == PREF_INT);
      g_mem = (rr_q == PREF_MEM);
    end
  end

  // Slots age by one every edge. A grant at latency L lands in position L-1 after the shift.
  always_comb begin
    slot_d = {1'b0, slot_q[MAXL:1]};
    for (int unsigned k = 0; k < MAXL; k++) begin
      owner_d[k] = owner_q[k+1];
    end
    owner_d[MAXL] = '0;

    if (g_int) begin
      slot_d[INT_LAT-1]  = 1'b1;
      owner_d[INT_LAT-1] = OWN_INT;
    end
    if (g_mem) begin
      slot_d[MEM_LAT-1]  = 1'b1;
      owner_d[MEM_LAT-1] = OWN_MEM;
    end
    if (g_mult) begin
      slot_d[MULT_LAT-1]  = 1'b1;
      owner_d[MULT_LAT-1] = OWN_MULT;
    end
    if (g_div) begin
      slot_d[DIV_LAT-1]  = 1'b1;
      owner_d[DIV_LAT-1] = OWN_DIV;
    end
  end

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (g_div) begin
      div_cnt_d = CW'(DIV_LAT - 1);
    end else if (div_busy) begin
      div_cnt_d = div_cnt_q - CW'(1);
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (g_mem) begin
      rr_d = PREF_INT;
    end else if (g_int) begin
      rr_d = PREF_MEM;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_q    <= '0;
      owner_q   <= '0;
      div_cnt_q <= '0;
      rr_q      <= PREF_INT;
    end else begin
      slot_q    <= slot_d;
      owner_q   <= owner_d;
      div_cnt_q <= div_cnt_d;
      rr_q      <= rr_d;
    end
  end

  assign sched.issue_int  = g_int;
  assign sched.issue_mem  = g_mem;
  assign sched.issue_mult = g_mult;
  assign sched.issue_div  = g_div;
  assign sched.div_busy   = div_busy;
  assign sched.cdb_valid  = slot_q[0];
  assign sched.cdb_owner  = owner_q[0];

endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// Bench for cdb_issue_scheduler: directed scenarios plus randomized traffic against a
// reference model that books results by absolute cycle number.
module tb_cdb_issue_scheduler;
  localparam int INT_LAT  = 1;
  localparam int MEM_LAT  = 1;
  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 7;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  cdb_issue_scheduler_if bus();

  cdb_issue_scheduler #(
    .INT_LAT  (INT_LAT),
    .MEM_LAT  (MEM_LAT),
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .sched   (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference state: owner_at[c] holds the unit whose result is on the CDB in absolute cycle c.
  int owner_at[int];
  bit taken[int];
  int lat[4] = '{INT_LAT, MEM_LAT, MULT_LAT, DIV_LAT};
  bit rr_m     = 1'b0;
  int last_div = -1000;

  logic [3:0] obs_iss;
  logic       obs_v, obs_b;
  logic [1:0] obs_o;
  logic [3:0] exp_iss;
  logic       exp_v, exp_b;
  logic [1:0] exp_o;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit elig(int u, logic [3:0] rdy, logic fl);
    return rdy[u] && !fl && !owner_at.exists(cyc + lat[u]) && !taken.exists(lat[u]);
  endfunction

  task automatic model_reset();
    owner_at.delete();
    rr_m     = 1'b0;
    last_div = -1000;
  endtask

  task automatic model_eval(input logic [3:0] rdy, input logic fl);
    bit ci, cm;
    taken.delete();
    exp_iss = '0;
    exp_b   = (cyc - last_div) < DIV_LAT;
    if (elig(3, rdy, fl) && !exp_b) begin
      exp_iss[3] = 1'b1;
      taken[lat[3]] = 1'b1;
    end
    if (elig(2, rdy, fl)) begin
      exp_iss[2] = 1'b1;
      taken[lat[2]] = 1'b1;
    end
    ci = elig(0, rdy, fl);
    cm = elig(1, rdy, fl);
    if (ci && cm && INT_LAT == MEM_LAT) begin
      exp_iss[rr_m ? 1 : 0] = 1'b1;
    end else begin
      exp_iss[0] = ci;
      exp_iss[1] = cm;
    end
    exp_v = owner_at.exists(cyc);
    exp_o = exp_v ? 2'(owner_at[cyc]) : 2'd0;
  endtask

  task automatic model_commit();
    for (int u = 0; u < 4; u++) begin
      if (exp_iss[u]) owner_at[cyc + lat[u]] = u;
    end
    if (exp_iss[0]) rr_m = 1'b1;
    if (exp_iss[1]) rr_m = 1'b0;
    if (exp_iss[3]) last_div = cyc;
    if (owner_at.exists(cyc)) owner_at.delete(cyc);
  endtask

  // One clock cycle: drive just after the rising edge, compare mid-cycle, then advance.
  // rdy bit order is {div, mult, mem, int}.
  task automatic step(input logic [3:0] rdy, input logic fl, input logic rst_n);
    bus.ready_int  = rdy[0];
    bus.ready_mem  = rdy[1];
    bus.ready_mult = rdy[2];
    bus.ready_div  = rdy[3];
    bus.flush      = fl;
    i_rst_n        = rst_n;
    #4;
    if (!rst_n) begin
      model_reset();
      exp_iss = '0;
      exp_v   = 1'b0;
      exp_o   = '0;
      exp_b   = 1'b0;
    end else begin
      model_eval(rdy, fl);
    end
    obs_iss = {bus.issue_div, bus.issue_mult, bus.issue_mem, bus.issue_int};
    obs_v   = bus.cdb_valid;
    obs_o   = bus.cdb_owner;
    obs_b   = bus.div_busy;
    check("issue", 32'(obs_iss), 32'(exp_iss));
    check("cdb_valid", 32'(obs_v), 32'(exp_v));
    check("cdb_owner", 32'(obs_o), 32'(exp_o));
    check("div_busy", 32'(obs_b), 32'(exp_b));
    if (rst_n) model_commit();
    cyc++;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    bus.ready_int  = 1'b0;
    bus.ready_mem  = 1'b0;
    bus.ready_mult = 1'b0;
    bus.ready_div  = 1'b0;
    bus.flush      = 1'b0;
    @(posedge i_clk);
    #1;

    // Reset with everything ready, then the first released cycle grants div+mult+int.
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    check("rst_issue", 32'(obs_iss), 32'd0);
    check("rst_valid", 32'(obs_v), 32'd0);
    check("rst_busy", 32'(obs_b), 32'd0);
    step(4'b1111, 1'b0, 1'b1);
    check("first_grants", 32'(obs_iss), 32'b1101);
    idle(8);

    // int/mem alternation
    do_reset();
    step(4'b0011, 1'b0, 1'b1); check("alt0", 32'(obs_iss), 32'b0001);
    step(4'b0011, 1'b0, 1'b1); check("alt1", 32'(obs_iss), 32'b0010); check("alt_own1", 32'(obs_o), 32'd0);
    step(4'b0011, 1'b0, 1'b1); check("alt2", 32'(obs_iss), 32'b0001); check("alt_own2", 32'(obs_o), 32'd1);
    step(4'b0011, 1'b0, 1'b1); check("alt3", 32'(obs_iss), 32'b0010); check("alt_own3", 32'(obs_o), 32'd0);
    step(4'b0000, 1'b0, 1'b1); check("alt_own4", 32'(obs_o), 32'd1);

    // mult slot blocks int three cycles later
    do_reset();
    step(4'b0100, 1'b0, 1'b1);
    idle(2);
    step(4'b0001, 1'b0, 1'b1); check("int_blocked", 32'(obs_iss), 32'b0000);
    step(4'b0001, 1'b0, 1'b1); check("int_retry", 32'(obs_iss), 32'b0001); check("mult_own", 32'(obs_o), 32'd2);
    step(4'b0000, 1'b0, 1'b1); check("int_own", 32'(obs_o), 32'd0); check("int_valid", 32'(obs_v), 32'd1);

    // continuous div
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(4'b1000, 1'b0, 1'b1);
      if (i == 0 || i == 7 || i == 14) check("div_grant", 32'(obs_iss[3]), 32'd1);
      if (i == 3) check("div_busy_mid", 32'(obs_b), 32'd1);
      if (i == 7 || i == 14) check("div_own", 32'(obs_o), 32'd3);
    end
    idle(8);

    // div slot blocks mult three cycles later
    do_reset();
    step(4'b1000, 1'b0, 1'b1);
    idle(2);
    step(4'b0100, 1'b0, 1'b1); check("mult_blocked", 32'(obs_iss), 32'b0000);
    step(4'b0100, 1'b0, 1'b1); check("mult_retry", 32'(obs_iss), 32'b0100);
    idle(2);
    step(4'b0000, 1'b0, 1'b1); check("div_res", 32'(obs_o), 32'd3);
    step(4'b0000, 1'b0, 1'b1); check("mult_res", 32'(obs_o), 32'd2);

    // flush blocks grants but in-flight results still drain
    do_reset();
    step(4'b0100, 1'b0, 1'b1);
    step(4'b1111, 1'b1, 1'b1); check("flush_none", 32'(obs_iss), 32'b0000);
    idle(2);
    step(4'b0000, 1'b0, 1'b1); check("flush_drain", 32'(obs_o), 32'd2); check("flush_valid", 32'(obs_v), 32'd1);

    // randomized traffic, with occasional flushes and mid-run resets
    for (int i = 0; i < 800; i++) begin
      logic [3:0] rdy;
      for (int b = 0; b < 4; b++) rdy[b] = ($urandom_range(0, 9) < 6);
      step(rdy, ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
